// File: rtl/dm_mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port among NUM_REQ cache controllers; aborts hung transfers.
// Latency: request seen in IDLE -> mem_req_valid next cycle; mem_rsp_ready at k -> rsp_ready at k+1.
// Backpressure: requests hold until their rsp_ready pulse; optional write-back lock via DM_ARB_WB_LOCK_EN.
module dm_mem_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 128,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LINE_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        rsp_ready,
    output logic [LINE_W-1:0]         rsp_data,
    output logic                      mem_req_valid,
    output logic                      mem_req_rw,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic [LINE_W-1:0]         mem_req_data,
    input  logic                      mem_rsp_ready,
    input  logic [LINE_W-1:0]         mem_rsp_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]      T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0]      P_LAST = PW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE    = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   cand;
    logic            found;
    logic [TW-1:0]   timer;
    logic            timer_last;

    // Scan starts just past the last owner so it gets lowest priority.
    always_comb begin
        state_d    = state;
        found      = 1'b0;
        winner     = '0;
        cand       = '0;
        timer_last = (timer == T_LAST);
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        case (state)
            S_IDLE:  if (found) state_d = S_WAIT;
            S_WAIT:  if (mem_rsp_ready || timer_last) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            rr_ptr        <= P_LAST;
            owner         <= '0;
            timer         <= '0;
            rsp_ready     <= '0;
            rsp_data      <= '0;
            mem_req_valid <= 1'b0;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            grant         <= '0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state       <= state_d;
            rsp_ready   <= '0;
            rsp_data    <= '0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner         <= winner;
                        rr_ptr        <= winner;
                        grant         <= ONE << winner;
                        busy          <= 1'b1;
                        timer         <= '0;
                        mem_req_valid <= 1'b1;
                        mem_req_rw    <= req_rw[winner];
                        mem_req_addr  <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
                        mem_req_data  <= req_data[int'(winner)*LINE_W +: LINE_W];
                    end
                end
                S_WAIT: begin
                    // A reply on the terminal cycle is a normal completion.
                    if (mem_rsp_ready || timer_last) begin
                        rsp_ready     <= ONE << owner;
                        mem_req_valid <= 1'b0;
                        mem_req_rw    <= 1'b0;
                        mem_req_addr  <= '0;
                        mem_req_data  <= '0;
                        if (mem_rsp_ready) begin
                            rsp_data <= mem_rsp_data;
`ifdef DM_ARB_WB_LOCK_EN
                            // Park the pointer just before the writer so its allocate read follows.
                            if (mem_req_rw)
                                rr_ptr <= (owner == '0) ? P_LAST : owner - PW'(1);
`endif
                        end else begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_RESP: begin
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_mem_arbiter.sv
// Directed bench for dm_mem_arbiter: expected responses queued at stimulus time, checked on rsp_ready.
module tb_dm_mem_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int LW = 128;

    typedef struct {
        logic [NR-1:0] gnt;
        logic [LW-1:0] dat;
        logic          tout;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid, req_rw;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_data;
    logic [NR-1:0]    rsp_ready;
    logic [LW-1:0]    rsp_data;
    logic             mem_req_valid, mem_req_rw;
    logic [AW-1:0]    mem_req_addr;
    logic [LW-1:0]    mem_req_data;
    logic             mem_rsp_ready;
    logic [LW-1:0]    mem_rsp_data;
    logic [NR-1:0]    grant;
    logic             busy, timeout_err;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    dm_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [NR-1:0] g, input logic [LW-1:0] d, input logic t);
        exp_t e;
        e.gnt = g; e.dat = d; e.tout = t;
        sb.push_back(e);
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, LW'(sb.size()), LW'(1));
        end else begin
            e = sb.pop_front();
            chk({tag, "_rsp_ready"}, LW'(rsp_ready), LW'(e.gnt));
            chk({tag, "_rsp_data"}, rsp_data, e.dat);
            chk({tag, "_timeout_err"}, LW'(timeout_err), LW'(e.tout));
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_grant"}, LW'(grant), '0);
        chk({tag, "_busy"}, LW'(busy), '0);
        chk({tag, "_mem_req_valid"}, LW'(mem_req_valid), '0);
        chk({tag, "_rsp_ready"}, LW'(rsp_ready), '0);
        chk({tag, "_rsp_data"}, rsp_data, '0);
        chk({tag, "_timeout_err"}, LW'(timeout_err), '0);
    endtask

    // Wait for the forwarded request, check owner/address, reply after dly cycles.
    task automatic do_xfer(input string tag, input logic [NR-1:0] eg, input logic [AW-1:0] ea,
                           input int dly, input logic [LW-1:0] d);
        int n;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_mem_req_valid"}, LW'(mem_req_valid), LW'(1));
        chk({tag, "_grant"}, LW'(grant), LW'(eg));
        chk({tag, "_mem_req_addr"}, LW'(mem_req_addr), LW'(ea));
        repeat (dly) tick();
        mem_rsp_ready = 1'b1;
        mem_rsp_data  = d;
        tick();
        mem_rsp_ready = 1'b0;
        mem_rsp_data  = '0;
        check_rsp(tag);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_rw = '0; req_addr = '0; req_data = '0;
        mem_rsp_ready = 1'b0; mem_rsp_data = '0;
        tick(); tick();
        all_zero("reset");
        rst = 1'b0;

        // Single read from requester 0.
        req_addr[31:0] = 32'h0000_1230;
        req_valid = 2'b01;
        push(2'b01, {16{8'hA5}}, 1'b0);
        tick();
        chk("rd_busy", LW'(busy), LW'(1));
        chk("rd_mem_req_rw", LW'(mem_req_rw), LW'(0));
        do_xfer("rd", 2'b01, 32'h0000_1230, 3, {16{8'hA5}});
        chk("rd_done_mem_req_valid", LW'(mem_req_valid), '0);
        req_valid = 2'b00;
        tick();
        chk("rd_idle_grant", LW'(grant), '0);
        chk("rd_idle_busy", LW'(busy), '0);

        // Contention from a fresh reset: strict alternation.
        rst = 1'b1; tick(); rst = 1'b0;
        req_addr = {32'h0000_0200, 32'h0000_0100};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) push((i % 2 == 0) ? 2'b01 : 2'b10, LW'(32'hC000 + i), 1'b0);
        for (int i = 0; i < 4; i++)
            do_xfer($sformatf("rr%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10,
                    (i % 2 == 0) ? 32'h100 : 32'h200, i, LW'(32'hC000 + i));
        req_valid = 2'b00;
        tick();

        // Timeout: requester 0 drops its request mid-transfer, memory never answers.
        req_valid = 2'b01;
        push(2'b01, '0, 1'b1);
        tick();
        chk("to_mem_req_valid", LW'(mem_req_valid), LW'(1));
        req_valid = 2'b00;
        repeat (7) tick();
        chk("to_early_rsp_ready", LW'(rsp_ready), '0);
        chk("to_early_err", LW'(timeout_err), '0);
        tick();
        check_rsp("to");
        chk("to_mem_req_valid_low", LW'(mem_req_valid), '0);
        mem_rsp_ready = 1'b1;
        mem_rsp_data  = {4{32'hDEAD_BEEF}};
        tick();
        mem_rsp_ready = 1'b0;
        mem_rsp_data  = '0;
        all_zero("late_rsp");

        // Reply on the terminal timeout cycle completes normally.
        req_valid = 2'b10;
        push(2'b10, {8{16'h5555}}, 1'b0);
        tick();
        repeat (7) tick();
        chk("term_pre_rsp_ready", LW'(rsp_ready), '0);
        mem_rsp_ready = 1'b1;
        mem_rsp_data  = {8{16'h5555}};
        tick();
        mem_rsp_ready = 1'b0;
        mem_rsp_data  = '0;
        check_rsp("term");
        req_valid = 2'b00;
        tick();

        // Requester 0 transfer so requester 1 is next in line.
        req_valid = 2'b01;
        push(2'b01, LW'(32'h1111), 1'b0);
        do_xfer("pre_lock", 2'b01, 32'h100, 1, LW'(32'h1111));
        req_valid = 2'b00;
        tick();

        // Requester 1 write then read, requester 0 pending throughout.
        req_data[2*LW-1:LW] = {4{32'hFEED_F00D}};
        req_rw = 2'b10;
        req_valid = 2'b11;
        push(2'b10, LW'(32'h2001), 1'b0);
`ifdef DM_ARB_WB_LOCK_EN
        push(2'b10, LW'(32'h2002), 1'b0);
        push(2'b01, LW'(32'h2003), 1'b0);
`else
        push(2'b01, LW'(32'h2002), 1'b0);
        push(2'b10, LW'(32'h2003), 1'b0);
`endif
        tick();
        chk("lock_wr_rw", LW'(mem_req_rw), LW'(1));
        chk("lock_wr_data", mem_req_data, {4{32'hFEED_F00D}});
        do_xfer("lock0", 2'b10, 32'h200, 1, LW'(32'h2001));
        req_rw = 2'b00;
`ifdef DM_ARB_WB_LOCK_EN
        do_xfer("lock1", 2'b10, 32'h200, 1, LW'(32'h2002));
        do_xfer("lock2", 2'b01, 32'h100, 1, LW'(32'h2003));
`else
        do_xfer("lock1", 2'b01, 32'h100, 1, LW'(32'h2002));
        do_xfer("lock2", 2'b10, 32'h200, 1, LW'(32'h2003));
`endif
        req_valid = 2'b00;
        tick();

        // Reset during WAIT cycle 2 abandons the transfer without a response.
        req_valid = 2'b10;
        tick();
        tick();
        chk("rst_wait_busy", LW'(busy), LW'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        all_zero("rst_mid");
        chk("rst_mid_addr", LW'(mem_req_addr), '0);
        req_valid = 2'b11;
        push(2'b01, LW'(32'h3333), 1'b0);
        do_xfer("post_rst", 2'b01, 32'h100, 2, LW'(32'h3333));
        req_valid = 2'b00;
        tick();

        chk("sb_drained", LW'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
